// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch prefetch stage.
package ifu_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } ifu_state_e;

  localparam int unsigned IFU_ADDR_W   = 32;
  localparam int unsigned IFU_DATA_W   = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  // PC increment for one instruction word, in bytes
  function automatic int unsigned pc_step(input int unsigned data_w);
    return data_w / 8;
  endfunction

  localparam int unsigned PC_STEP = IFU_DATA_W / 8;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous prefetch FIFO: push/pop/flush with occupancy count.
// Push while full is accepted only together with a pop.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             hclk_i,
  input  logic             hresetn_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; no reset needed since count gates visibility
  always_ff @(posedge hclk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy update; flush wins over push/pop
  always_ff @(posedge hclk_i) begin
    if (!hresetn_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch prefetch stage ahead of the AHB-Lite master.
// Issues sequential word reads, buffers returns in a FIFO, and discards
// in-flight returns after a redirect.
// Optional: define IFU_BYPASS_EN for a 0-cycle path from rdata_i to decode
// when the FIFO is empty.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IFU_ADDR_W,
  parameter int unsigned           DATA_WIDTH = IFU_DATA_W,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter int unsigned           MAX_OUTST  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
  input  logic                  hclk_i,
  input  logic                  hresetn_i,
  input  logic                  fetch_en_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  req_o,
  input  logic                  ready_i,
  output logic                  wr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rvalid_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                  instr_ready_i
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(pc_step(DATA_WIDTH));

  ifu_state_e            state;
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc;
  logic [OW-1:0]         outst_cnt, discard_cnt, pending;
  logic [CW-1:0]         fifo_cnt;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0]         fifo_rdata;
  logic [31:0]           credit_sum;
  logic                  accept, rsp_keep, byp_valid, byp_take;

  assign wr_o    = 1'b0;
  assign wdata_o = '0;
  assign addr_o  = fetch_pc;

  // Reads in flight, less any returning this cycle: what a redirect must discard
  assign pending    = outst_cnt - OW'(rvalid_i);
  // Reserve a FIFO slot for every outstanding read so returns never overflow
  assign credit_sum = 32'(fifo_cnt) + 32'(outst_cnt);

  assign req_o = (state == S_FETCH) & fetch_en_i & ~redirect_i
               & (outst_cnt < OW'(MAX_OUTST))
               & (credit_sum < 32'(FIFO_DEPTH)) & ~fifo_full;
  assign accept = req_o & ready_i;

  // A return is kept only when nothing is pending discard and no redirect kills it
  assign rsp_keep = rvalid_i & (discard_cnt == '0) & ~redirect_i;

`ifdef IFU_BYPASS_EN
  assign byp_valid = fifo_empty & rsp_keep;
`else
  assign byp_valid = 1'b0;
`endif
  assign byp_take  = byp_valid & instr_ready_i;
  assign fifo_push = rsp_keep & ~byp_take;
  assign fifo_pop  = instr_ready_i;

  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hclk_i    (hclk_i),
    .hresetn_i (hresetn_i),
    .push      (fifo_push),
    .wdata     ({resp_pc, rdata_i}),
    .pop       (fifo_pop),
    .flush     (redirect_i),
    .rdata     (fifo_rdata),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Decode view: FIFO head first, bypass only when the FIFO is empty
  always_comb begin
    instr_valid_o = ~fifo_empty | byp_valid;
    instr_o       = '0;
    instr_pc_o    = RESET_PC;
    if (!fifo_empty) begin
      instr_o    = fifo_rdata[DATA_WIDTH-1:0];
      instr_pc_o = fifo_rdata[EW-1:DATA_WIDTH];
    end else if (byp_valid) begin
      instr_o    = rdata_i;
      instr_pc_o = resp_pc;
    end
  end

  // PCs and read-tracking counters
  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outst_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      outst_cnt <= outst_cnt + OW'(accept) - OW'(rvalid_i);
      if (redirect_i) begin
        fetch_pc    <= redirect_pc_i;
        resp_pc     <= redirect_pc_i;
        discard_cnt <= pending;
      end else begin
        if (accept) fetch_pc <= fetch_pc + STEP;
        if (rvalid_i && discard_cnt != '0) discard_cnt <= discard_cnt - OW'(1);
        else if (rvalid_i)                 resp_pc     <= resp_pc + STEP;
      end
    end
  end

  // Fetch controller
  always_ff @(posedge hclk_i) begin
    if (!hresetn_i) begin
      state <= S_IDLE;
    end else if (redirect_i && pending != '0) begin
      state <= S_DRAIN;
    end else begin
      case (state)
        S_IDLE:  if (fetch_en_i) state <= S_FETCH;
        S_FETCH: if (!fetch_en_i && outst_cnt == '0) state <= S_IDLE;
        S_DRAIN: if (discard_cnt == '0 || redirect_i)
                   state <= fetch_en_i ? S_FETCH : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch; a simple master model returns each
// accepted read one cycle later when auto_resp is set.
module tb_ifu_prefetch;

  logic        hclk_i = 1'b0;
  logic        hresetn_i, fetch_en_i, redirect_i, ready_i, rvalid_i, instr_ready_i;
  logic [31:0] redirect_pc_i, rdata_i;
  logic        req_o, wr_o, instr_valid_o;
  logic [31:0] addr_o, wdata_o, instr_o, instr_pc_o;

  int vectors = 0;
  int miscompares = 0;
  bit auto_resp = 0;

  logic        s_req, s_acc, s_ival;
  logic [31:0] s_addr, s_instr, s_pc;
  logic [31:0] acc_q[$], dpc_q[$], dins_q[$];

  ifu_prefetch dut (
    .hclk_i        (hclk_i),
    .hresetn_i     (hresetn_i),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .req_o         (req_o),
    .ready_i       (ready_i),
    .wr_o          (wr_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .rdata_i       (rdata_i),
    .rvalid_i      (rvalid_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  always #5 hclk_i = ~hclk_i;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One cycle: sample mid-cycle, then the edge, then master response
  task automatic step();
    @(negedge hclk_i);
    s_req   = req_o;
    s_acc   = req_o & ready_i & hresetn_i;
    s_addr  = addr_o;
    s_ival  = instr_valid_o;
    s_instr = instr_o;
    s_pc    = instr_pc_o;
    if (s_acc) acc_q.push_back(addr_o);
    if (instr_valid_o && instr_ready_i && hresetn_i) begin
      dpc_q.push_back(instr_pc_o);
      dins_q.push_back(instr_o);
    end
    @(posedge hclk_i); #1;
    if (auto_resp) begin
      rvalid_i = s_acc;
      rdata_i  = s_acc ? dat(s_addr) : 32'h0;
    end
  endtask

  task automatic clear_q();
    acc_q.delete(); dpc_q.delete(); dins_q.delete();
  endtask

  task automatic do_reset();
    hresetn_i = 0; fetch_en_i = 0; redirect_i = 0; redirect_pc_i = 0;
    ready_i = 0; rvalid_i = 0; rdata_i = 0; instr_ready_i = 0; auto_resp = 0;
    step(); step();
    hresetn_i = 1;
    clear_q();
  endtask

  task automatic test_reset();
    do_reset();
    step();
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", s_req); end
    vectors++; if (s_ival !== 1'b0) begin miscompares++; $display("FAIL reset_ival got %b want 0", s_ival); end
    vectors++; if (s_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want 0", s_addr); end
    vectors++; if (s_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want 0", s_instr); end
    vectors++; if (s_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 0", s_pc); end
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 1; auto_resp = 1;
    repeat (12) step();
    vectors++;
    if (acc_q.size() < 4 || dpc_q.size() < 4) begin
      miscompares++; $display("FAIL seq_count got acc=%0d dlv=%0d want >=4", acc_q.size(), dpc_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++; if (acc_q[i] !== 32'(4*i)) begin miscompares++; $display("FAIL seq_addr[%0d] got %h want %h", i, acc_q[i], 32'(4*i)); end
        vectors++; if (dpc_q[i] !== 32'(4*i)) begin miscompares++; $display("FAIL seq_pc[%0d] got %h want %h", i, dpc_q[i], 32'(4*i)); end
        vectors++; if (dins_q[i] !== dat(32'(4*i))) begin miscompares++; $display("FAIL seq_instr[%0d] got %h want %h", i, dins_q[i], dat(32'(4*i))); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 0; auto_resp = 1;
    repeat (10) step();
    vectors++; if (acc_q.size() != 4) begin miscompares++; $display("FAIL bp_accepts got %0d want 4", acc_q.size()); end
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_full got %b want 0", s_req); end
    vectors++; if (s_ival !== 1'b1 || s_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=0", s_ival, s_pc); end
    instr_ready_i = 1;
    step();
    instr_ready_i = 0;
    repeat (6) step();
    vectors++; if (acc_q.size() != 5) begin miscompares++; $display("FAIL bp_one_more got %0d want 5", acc_q.size()); end
    else begin
      vectors++; if (acc_q[4] !== 32'h10) begin miscompares++; $display("FAIL bp_addr5 got %h want 10", acc_q[4]); end
    end
    vectors++; if (s_pc !== 32'h4 || s_instr !== dat(32'h4)) begin miscompares++; $display("FAIL bp_newhead got pc=%h i=%h want pc=4 i=%h", s_pc, s_instr, dat(32'h4)); end
  endtask

  task automatic test_redirect();
    bit stale;
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 1;
    step(); step(); step();                    // idle, accept 0x0, accept 0x4
    redirect_i = 1; redirect_pc_i = 32'h100;
    step();
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_in_redirect got %b want 0", s_req); end
    stale = s_ival;
    redirect_i = 0; rvalid_i = 1; rdata_i = 32'hDEAD_0000;
    step(); stale |= s_ival;
    rdata_i = 32'hDEAD_0004;
    step(); stale |= s_ival;
    vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_drain got %b want 0", s_req); end
    rvalid_i = 0; auto_resp = 1; clear_q();
    step(); stale |= s_ival;
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL rd_stale got %b want 0", stale); end
    repeat (8) step();
    vectors++;
    if (acc_q.size() < 1 || dpc_q.size() < 1) begin
      miscompares++; $display("FAIL rd_resume got acc=%0d dlv=%0d want >=1", acc_q.size(), dpc_q.size());
    end else begin
      vectors++; if (acc_q[0] !== 32'h100) begin miscompares++; $display("FAIL rd_addr got %h want 100", acc_q[0]); end
      vectors++; if (dpc_q[0] !== 32'h100 || dins_q[0] !== dat(32'h100)) begin miscompares++; $display("FAIL rd_first got pc=%h i=%h want pc=100 i=%h", dpc_q[0], dins_q[0], dat(32'h100)); end
    end
  endtask

  task automatic test_redirect_rvalid();
    bit stale;
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 1;
    step(); step(); step();                    // idle, accept 0x0, accept 0x4
    redirect_i = 1; redirect_pc_i = 32'h200; rvalid_i = 1; rdata_i = 32'hBAD0_0000;
    step(); stale = s_ival;
    redirect_i = 0; rdata_i = 32'hBAD0_0004;
    step(); stale |= s_ival;
    rvalid_i = 0; auto_resp = 1; clear_q();
    step(); stale |= s_ival;
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL rv_stale got %b want 0", stale); end
    repeat (8) step();
    vectors++;
    if (acc_q.size() < 1 || dpc_q.size() < 1) begin
      miscompares++; $display("FAIL rv_resume got acc=%0d dlv=%0d want >=1", acc_q.size(), dpc_q.size());
    end else begin
      vectors++; if (acc_q[0] !== 32'h200) begin miscompares++; $display("FAIL rv_addr got %h want 200", acc_q[0]); end
      vectors++; if (dpc_q[0] !== 32'h200 || dins_q[0] !== dat(32'h200)) begin miscompares++; $display("FAIL rv_first got pc=%h i=%h want pc=200 i=%h", dpc_q[0], dins_q[0], dat(32'h200)); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 1; auto_resp = 1;
    redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 0; clear_q();
    repeat (6) step();
    vectors++;
    if (acc_q.size() < 3 || dpc_q.size() < 2) begin
      miscompares++; $display("FAIL wrap_count got acc=%0d dlv=%0d want >=3/>=2", acc_q.size(), dpc_q.size());
    end else begin
      vectors++; if (acc_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr0 got %h want fffffffc", acc_q[0]); end
      vectors++; if (acc_q[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr1 got %h want 0", acc_q[1]); end
      vectors++; if (acc_q[2] !== 32'h4) begin miscompares++; $display("FAIL wrap_addr2 got %h want 4", acc_q[2]); end
      vectors++; if (dpc_q[1] !== 32'h0 || dins_q[1] !== dat(32'h0)) begin miscompares++; $display("FAIL wrap_pc1 got pc=%h i=%h want pc=0 i=%h", dpc_q[1], dins_q[1], dat(32'h0)); end
    end
  endtask

  task automatic test_latency();
    do_reset();
    fetch_en_i = 1; ready_i = 1; instr_ready_i = 1;
    step(); step();                            // idle, accept 0x0
    fetch_en_i = 0; rvalid_i = 1; rdata_i = dat(32'h0);
    step();
`ifdef IFU_BYPASS_EN
    vectors++; if (s_ival !== 1'b1 || s_pc !== 32'h0 || s_instr !== dat(32'h0)) begin miscompares++; $display("FAIL lat_bypass got v=%b pc=%h i=%h want v=1 pc=0 i=%h", s_ival, s_pc, s_instr, dat(32'h0)); end
    rvalid_i = 0;
    step();
    vectors++; if (s_ival !== 1'b0) begin miscompares++; $display("FAIL lat_not_pushed got %b want 0", s_ival); end
`else
    vectors++; if (s_ival !== 1'b0) begin miscompares++; $display("FAIL lat_same_cycle got %b want 0", s_ival); end
    rvalid_i = 0;
    step();
    vectors++; if (s_ival !== 1'b1 || s_pc !== 32'h0 || s_instr !== dat(32'h0)) begin miscompares++; $display("FAIL lat_next_cycle got v=%b pc=%h i=%h want v=1 pc=0 i=%h", s_ival, s_pc, s_instr, dat(32'h0)); end
`endif
    step();
    vectors++; if (s_ival !== 1'b0) begin miscompares++; $display("FAIL lat_drained got %b want 0", s_ival); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_rvalid();
    test_wrap();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction-fetch prefetch stage that sits directly upstream of the AHB-Lite master.
- Generates sequential word-aligned read requests on the master's local request interface.
- Collects same-cycle read returns into a small FIFO and presents {pc, instr} to decode over a valid/ready handshake.
- Handles PC redirects (branch/trap) by flushing the FIFO and discarding in-flight responses.

Parameters:
- ADDR_WIDTH, 32, address and PC width
- DATA_WIDTH, 32, instruction word width; PC step is DATA_WIDTH/8
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >=2)
- MAX_OUTST, 2, maximum issued-but-unreturned reads
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- hclk_i  in  1  clock
- hresetn_i  in  1  reset, synchronous, active-low
- fetch_en_i  in  1  1 = issuing allowed
- redirect_i  in  1  one-cycle pulse: restart fetch at redirect_pc_i
- redirect_pc_i  in  ADDR_WIDTH  new PC, word-aligned
- req_o  out  1  read request to the master
- ready_i  in  1  master accepts; beat accepted when req_o & ready_i
- wr_o  out  1  tied 0 (reads only)
- addr_o  out  ADDR_WIDTH  request address (= fetch_pc)
- wdata_o  out  DATA_WIDTH  tied 0
- rdata_i  in  DATA_WIDTH  read data, valid only when rvalid_i
- rvalid_i  in  1  one-cycle read-return pulse, in issue order
- instr_valid_o  out  1  FIFO head valid
- instr_o  out  DATA_WIDTH  instruction at FIFO head
- instr_pc_o  out  ADDR_WIDTH  PC of instr_o
- instr_ready_i  in  1  decode consumes head when instr_valid_o & instr_ready_i

Behaviour:
- Reset (synchronous, hresetn_i=0 at the clock edge):
  - fetch_pc and resp_pc = RESET_PC.
  - outst_cnt, discard_cnt and FIFO count = 0.
  - State = S_IDLE.
  - Outputs: req_o=0, instr_valid_o=0, addr_o=RESET_PC, instr_o=0, instr_pc_o=RESET_PC.
- Reset asserted mid-operation drops all FIFO contents and counters. Responses arriving after reset release are not expected; the master is reset together with this block.
- States and transitions:
  - S_IDLE -> S_FETCH when fetch_en_i=1.
  - S_FETCH -> S_IDLE when fetch_en_i=0 and outst_cnt=0.
  - Any state -> S_DRAIN on redirect_i when (outst_cnt minus responses returning this cycle) > 0.
  - S_DRAIN -> S_FETCH (or S_IDLE if fetch_en_i=0) when discard_cnt reaches 0.
- Issue rule, combinational:
  - req_o = (state==S_FETCH) & fetch_en_i & !redirect_i & (outst_cnt < MAX_OUTST) & (fifo_cnt + outst_cnt < FIFO_DEPTH).
  - Credits guarantee that every returned word has a FIFO slot; no response is ever dropped for lack of space.
- On accept: fetch_pc += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; outst_cnt += 1.
- Simultaneous accept and rvalid_i leaves outst_cnt unchanged.
- Response with discard_cnt>0: the word is dropped, discard_cnt -= 1, outst_cnt -= 1.
- Response otherwise: push {resp_pc, rdata_i}; resp_pc += DATA_WIDTH/8.
- Redirect, at the clock edge:
  - FIFO flushed, including any simultaneous push and pop.
  - fetch_pc and resp_pc = redirect_pc_i.
  - discard_cnt = outst_cnt minus any rvalid_i in the same cycle. That rvalid beat is itself discarded.
  - No request is issued in the redirect cycle.
- A second redirect during S_DRAIN reloads the PCs; discard_cnt continues counting down the remaining outstanding beats.
- The FIFO head is registered. Latency from rvalid_i to instr_valid_o is 1 cycle.
- Push and pop in the same cycle when full is legal, because the credit rule prevents overflow.
- Pop when empty is ignored.

Optional Feature:
- Macro IFU_BYPASS_EN.
- Defined: when the FIFO is empty, no discard is pending and rvalid_i=1, instr_valid_o/instr_o/instr_pc_o are driven combinationally from rdata_i/resp_pc. This gives 0-cycle latency. If instr_ready_i=1 the word is consumed and not pushed; otherwise it is pushed.
- Undefined: outputs come only from the FIFO (1-cycle latency).

Decomposition:
- Package ifu_pkg:
  - state encoding (S_IDLE, S_FETCH, S_DRAIN)
  - PC_STEP = DATA_WIDTH/8
  - RESET_PC default
- Sub-module ifu_fifo: synchronous FIFO of width ADDR_WIDTH+DATA_WIDTH with push, pop, flush and count, plus full/empty flags.

Test Plan:
- Reset, fetch_en_i=1, ready_i=1, master returns each read 1 cycle after accept -> addresses 0x0, 0x4, 0x8, ...; instr_pc_o sequence 0x0, 0x4, ... with the matching data.
- instr_ready_i=0 with FIFO_DEPTH=4 -> exactly 4 accepted requests, then req_o=0; holding instr_ready_i=1 for one cycle frees one credit and gives exactly one more request.
- Redirect to 0x100 with 2 reads outstanding -> both returns dropped; first instr_pc_o after redirect = 0x100; no stale word ever has instr_valid_o=1.
- Redirect in the same cycle as rvalid_i, with 1 other read outstanding -> discard_cnt=1; that beat and the next are both dropped.
- fetch_pc=0xFFFF_FFFC, accepted -> next addr_o=0x0000_0000 (wrap).
- IFU_BYPASS_EN defined, empty FIFO, rvalid_i with instr_ready_i=1 -> instr_valid_o=1 in the same cycle; FIFO count remains 0.
